alu_resp_buf: RTL and testbench
===============================

# alu_resp_buf

Response buffer that sits directly downstream of `alu_16b`. It captures the ALU's 17-bit result together with the operation code and derives condition flags. Entries are held in an in-order FIFO and released to the consumer over a valid/ready handshake, so back-pressure never stalls or corrupts the combinational ALU stage.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, minimum 2.
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_i` input 1: reset, synchronous, active-high.
- `valid_i` input 1: upstream result valid.
- `ready_o` output 1: buffer can accept an entry.
- `ctrl_i` input 3: ALU op code that produced `res_i`.
- `res_i` input 17: ALU result; bit 16 is the carry/borrow.
- `valid_o` output 1: head entry valid.
- `ready_i` input 1: consumer accepts the head entry.
- `res_o` output 16: head result, bits [15:0].
- `op_o` output 3: head op code.
- `flag_c_o` output 1: carry/borrow.
- `flag_z_o` output 1: zero.
- `flag_n_o` output 1: negative.
- `flag_e_o` output 1: illegal op code.
- `count_o` output $clog2(DEPTH)+1: occupancy.
- `stat_clr_i`, `stat_push_cnt_o` [15:0], `stat_carry_cnt_o` [15:0], `stat_zero_cnt_o` [15:0]: present only under the macro; see Configuration.

## Operation
- Push when `valid_i && ready_o`. Pop when `valid_o && ready_i`.
- `ready_o = (count < DEPTH)`. It is a registered-state function only, with no combinational path from `ready_i`.
- When full, a push is refused even if a pop happens in the same cycle.
- Flags are computed at push time and stored with the entry:
  - `z = (res_i[15:0] == 0)`
  - `n = res_i[15]`
  - `c = res_i[16]` for `ctrl_i` ∈ {000 ADD, 001 SUB, 101–111}; `c` is forced to 0 for 010 AND, 011 OR, 100 XOR.
  - `e = 1` for `ctrl_i` ≥ 3'b101; these codes are treated as ADD for the carry rule.
- Simultaneous push and pop at 0 < count < DEPTH: count is unchanged and order is preserved.
- Pointers wrap modulo `DEPTH`. `count_o` ranges 0..DEPTH.
- When `valid_o` = 0, `res_o`, `op_o` and all flags are driven 0.
- A pop or push while `rst_i` is high is ignored.

## Timing
- Reset (and `rst_i` asserted mid-operation): next cycle count=0, both pointers 0, `valid_o`=0, `ready_o`=1, all data/flag outputs 0, stats 0. Stored entries are discarded.
- Latency is 1 cycle, with no bypass. An entry pushed at edge N is visible on the outputs after edge N, in cycle N+1.
- Freed space after a pop at edge N raises `ready_o` in cycle N+1.
- Back-to-back throughput is one entry per cycle whenever not full.

## Configuration
- `ALU_RESP_STATS_EN` defined:
  - Adds `stat_clr_i` and three 16-bit saturating counters.
  - `stat_push_cnt_o` increments on every accepted push.
  - `stat_carry_cnt_o` increments on pushes whose stored `c` = 1.
  - `stat_zero_cnt_o` increments on pushes whose stored `z` = 1.
  - Counters hold at 0xFFFF.
  - `stat_clr_i` zeroes them next cycle and has priority over a same-cycle increment.
  - Reset clears them.
- Undefined: these ports and the counter logic are absent, and FIFO behaviour is identical.

## Structure
- `alu_pkg` holds the shared definitions:
  - `alu_op_e` enum: ADD=0, SUB=1, AND=2, OR=3, XOR=4.
  - `ALU_W = 16`.
  - `alu_resp_t` packed struct: res[15:0], op[2:0], c, z, n, e.
- One sub-module, `alu_resp_fifo`:
  - Generic synchronous FIFO parameterised on width and `DEPTH`.
  - Provides push, pop, full, empty and count.
- Flag derivation and stats live in `alu_resp_buf`.

## Test plan
- Reset: assert `rst_i` 1 cycle with 3 entries stored -> `valid_o`=0, `ready_o`=1, `count_o`=0, all outputs 0.
- ADD carry: `ctrl_i`=000, `res_i`=17'h1_0000 pushed in cycle N -> cycle N+1 `valid_o`=1, `res_o`=16'h0000, c=1, z=1, n=0, e=0.
- SUB borrow / logic carry mask:
  - `ctrl_i`=001, `res_i`=17'h1_FFFF -> `res_o`=16'hFFFF, c=1, z=0, n=1.
  - `ctrl_i`=100, `res_i`=17'h1_0003 -> c=0, `res_o`=16'h0003.
- Full/back-pressure (DEPTH=4): hold `ready_i`=0 and push AND results 1, 2, 3, 4 -> `count_o`=4, `ready_o`=0, and a 5th push is not accepted. Then set `ready_i`=1 -> `res_o` pops 1, 2, 3, 4 on consecutive cycles, and `ready_o`=1 the cycle after the first pop.
- Illegal op plus simultaneous push/pop: at `count_o`=2, push `ctrl_i`=3'b110 with `res_i`=17'h0_0005 while popping -> `count_o` stays 2, order is preserved, and that entry later shows e=1, c=0, `res_o`=5.
- Stats (`ALU_RESP_STATS_EN`): push three entries, two with c=1 and one with z=1 -> push=3, carry=2, zero=1. Assert `stat_clr_i` together with a push -> all counters 0 next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU response definitions: op codes, result width, response payload and flag helpers.
package alu_pkg;

  localparam int unsigned ALU_W  = 16;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned STAT_W = 16;

  typedef enum logic [OP_W-1:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    XOR = 3'd4
  } alu_op_e;

  typedef struct packed {
    logic [ALU_W-1:0] res;
    logic [OP_W-1:0]  op;
    logic             c;
    logic             z;
    logic             n;
    logic             e;
  } alu_resp_t;

  localparam int unsigned RESP_W = $bits(alu_resp_t);

  // Codes above XOR are flagged illegal but keep the ADD carry rule.
  function automatic alu_resp_t derive_resp(input logic [OP_W-1:0] ctrl,
                                            input logic [ALU_W:0]  res);
    alu_resp_t r;
    r.res = res[ALU_W-1:0];
    r.op  = ctrl;
    r.z   = (res[ALU_W-1:0] == ALU_W'(0));
    r.n   = res[ALU_W-1];
    r.e   = (ctrl > OP_W'(XOR));
    r.c   = res[ALU_W] & ~(ctrl inside {OP_W'(AND), OP_W'(OR), OP_W'(XOR)});
    return r;
  endfunction

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/alu_resp_fifo.sv
// Generic synchronous in-order FIFO; DEPTH must be a power of two (>= 2).
module alu_resp_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == CNT_W'(0));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is only observed while count is nonzero.
  always_ff @(posedge clk_i) begin
    if (push_ok && !rst_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/alu_resp_buf.sv
// Response buffer behind alu_16b: derives flags at push time and queues results for a valid/ready consumer.
// Optional push/carry/zero statistics counters are enabled with ALU_RESP_STATS_EN.
module alu_resp_buf
  import alu_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [OP_W-1:0]   ctrl_i,
  input  logic [ALU_W:0]    res_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [ALU_W-1:0]  res_o,
  output logic [OP_W-1:0]   op_o,
  output logic              flag_c_o,
  output logic              flag_z_o,
  output logic              flag_n_o,
  output logic              flag_e_o,
  output logic [CNT_W-1:0]  count_o
`ifdef ALU_RESP_STATS_EN
  ,
  input  logic              stat_clr_i,
  output logic [STAT_W-1:0] stat_push_cnt_o,
  output logic [STAT_W-1:0] stat_carry_cnt_o,
  output logic [STAT_W-1:0] stat_zero_cnt_o
`endif
);

  alu_resp_t         resp_in;
  alu_resp_t         resp_head;
  alu_resp_t         resp_out;
  logic [RESP_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  assign resp_in = derive_resp(ctrl_i, res_i);

  // Handshakes depend only on registered occupancy, never on ready_i.
  assign ready_o = ~fifo_full;
  assign valid_o = ~fifo_empty;
  assign push    = valid_i & ready_o;
  assign pop     = valid_o & ready_i;

  alu_resp_fifo #(
    .WIDTH (RESP_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (resp_in),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count_o)
  );

  assign resp_head = alu_resp_t'(fifo_rdata);
  assign resp_out  = valid_o ? resp_head : '0;

  assign res_o    = resp_out.res;
  assign op_o     = resp_out.op;
  assign flag_c_o = resp_out.c;
  assign flag_z_o = resp_out.z;
  assign flag_n_o = resp_out.n;
  assign flag_e_o = resp_out.e;

`ifdef ALU_RESP_STATS_EN
  logic [STAT_W-1:0] stat_push_q, stat_push_d;
  logic [STAT_W-1:0] stat_carry_q, stat_carry_d;
  logic [STAT_W-1:0] stat_zero_q, stat_zero_d;

  // Saturating counters; clear wins over a same-cycle increment.
  always_comb begin
    stat_push_d  = stat_push_q;
    stat_carry_d = stat_carry_q;
    stat_zero_d  = stat_zero_q;
    if (stat_clr_i) begin
      stat_push_d  = '0;
      stat_carry_d = '0;
      stat_zero_d  = '0;
    end else if (push) begin
      stat_push_d = sat_inc(stat_push_q);
      if (resp_in.c) stat_carry_d = sat_inc(stat_carry_q);
      if (resp_in.z) stat_zero_d  = sat_inc(stat_zero_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_push_q  <= '0;
      stat_carry_q <= '0;
      stat_zero_q  <= '0;
    end else begin
      stat_push_q  <= stat_push_d;
      stat_carry_q <= stat_carry_d;
      stat_zero_q  <= stat_zero_d;
    end
  end

  assign stat_push_cnt_o  = stat_push_q;
  assign stat_carry_cnt_o = stat_carry_q;
  assign stat_zero_cnt_o  = stat_zero_q;
`endif

endmodule

// File: tb/tb_alu_resp_buf.sv
// Scoreboard bench for alu_resp_buf: directed pushes enqueue hand-computed responses, a monitor checks pops.
module tb_alu_resp_buf;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [2:0]  ctrl_i;
  logic [16:0] res_i;
  logic        valid_o;
  logic        ready_i;
  logic [15:0] res_o;
  logic [2:0]  op_o;
  logic        flag_c_o, flag_z_o, flag_n_o, flag_e_o;
  logic [2:0]  count_o;
`ifdef ALU_RESP_STATS_EN
  logic        stat_clr_i;
  logic [15:0] stat_push_cnt_o, stat_carry_cnt_o, stat_zero_cnt_o;
`endif

  alu_resp_t sb[$];
  alu_resp_t exp_r, act_r;
  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  alu_resp_buf #(.DEPTH(4)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .ctrl_i   (ctrl_i),
    .res_i    (res_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .res_o    (res_o),
    .op_o     (op_o),
    .flag_c_o (flag_c_o),
    .flag_z_o (flag_z_o),
    .flag_n_o (flag_n_o),
    .flag_e_o (flag_e_o),
    .count_o  (count_o)
`ifdef ALU_RESP_STATS_EN
    ,
    .stat_clr_i       (stat_clr_i),
    .stat_push_cnt_o  (stat_push_cnt_o),
    .stat_carry_cnt_o (stat_carry_cnt_o),
    .stat_zero_cnt_o  (stat_zero_cnt_o)
`endif
  );

  // Monitor: every handshake pop is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!rst_i && valid_o && ready_i) begin
      n_vec++;
      act_r = {res_o, op_o, flag_c_o, flag_z_o, flag_n_o, flag_e_o};
      if (sb.size() == 0) begin
        n_miss++;
        $display("FAIL pop_unexpected: got res=%h op=%0d with nothing expected", res_o, op_o);
      end else begin
        exp_r = sb.pop_front();
        if (act_r !== exp_r) begin
          n_miss++;
          $display("FAIL pop_entry: got res=%h op=%0d cznE=%b%b%b%b, required res=%h op=%0d cznE=%b%b%b%b",
                   act_r.res, act_r.op, act_r.c, act_r.z, act_r.n, act_r.e,
                   exp_r.res, exp_r.op, exp_r.c, exp_r.z, exp_r.n, exp_r.e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one push cycle; enqueues the hand-computed response only if acceptance is expected.
  task automatic push_ent(input logic [2:0] ctrl, input logic [16:0] res,
                          input logic [15:0] er, input logic ec, input logic ez,
                          input logic en, input logic ee, input logic acc);
    valid_i = 1'b1;
    ctrl_i  = ctrl;
    res_i   = res;
    @(negedge clk);
    chk("ready_at_push", {31'd0, ready_o}, {31'd0, acc});
    if (acc) sb.push_back({er, ctrl, ec, ez, en, ee});
    tick();
    valid_i = 1'b0;
    ctrl_i  = '0;
    res_i   = '0;
  endtask

  task automatic chk_idle_outputs(input string nm);
    @(negedge clk);
    chk({nm, "_valid"}, {31'd0, valid_o}, 32'd0);
    chk({nm, "_ready"}, {31'd0, ready_o}, 32'd1);
    chk({nm, "_count"}, {29'd0, count_o}, 32'd0);
    chk({nm, "_data"}, {9'd0, res_o, op_o, flag_c_o, flag_z_o, flag_n_o, flag_e_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    ctrl_i  = '0;
    res_i   = '0;
`ifdef ALU_RESP_STATS_EN
    stat_clr_i = 1'b0;
`endif
    repeat (2) tick();
    rst_i = 1'b0;
    chk_idle_outputs("por");
    tick();

    // Reset with three stored entries discards them.
    push_ent(3'd0, 17'h00001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push_ent(3'd0, 17'h00002, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push_ent(3'd0, 17'h00003, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("count_before_rst", {29'd0, count_o}, 32'd3);
    tick();
    rst_i = 1'b1;
    sb.delete();
    tick();
    rst_i = 1'b0;
    chk_idle_outputs("midrst");
    tick();

    // ADD carry with one-cycle latency, then back-to-back flag cases.
    ready_i = 1'b1;
    push_ent(3'd0, 17'h10000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("latency_valid", {31'd0, valid_o}, 32'd1);
    chk("latency_count", {29'd0, count_o}, 32'd1);
    tick();
    push_ent(3'd1, 17'h1FFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    push_ent(3'd4, 17'h10003, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push_ent(3'd3, 17'h18000, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    push_ent(3'd2, 17'h10000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (3) tick();
    @(negedge clk);
    chk("drain1_count", {29'd0, count_o}, 32'd0);
    tick();

    // Fill to DEPTH under back-pressure; fifth push refused.
    ready_i = 1'b0;
    push_ent(3'd2, 17'h00001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push_ent(3'd2, 17'h00002, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push_ent(3'd2, 17'h00003, 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push_ent(3'd2, 17'h00004, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push_ent(3'd2, 17'h00005, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("full_count", {29'd0, count_o}, 32'd4);
    tick();
    ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_count", {29'd0, count_o}, 32'(4 - i));
      chk("drain_valid", {31'd0, valid_o}, 32'd1);
      chk("drain_ready", {31'd0, ready_o}, (i == 0) ? 32'd0 : 32'd1);
      tick();
    end
    @(negedge clk);
    chk("drain2_count", {29'd0, count_o}, 32'd0);
    tick();

    // Illegal op pushed during a pop at count 2.
    ready_i = 1'b0;
    push_ent(3'd0, 17'h00007, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push_ent(3'd1, 17'h00000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("pp_count_before", {29'd0, count_o}, 32'd2);
    tick();
    ready_i = 1'b1;
    push_ent(3'd6, 17'h00005, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    ready_i = 1'b0;
    @(negedge clk);
    chk("pp_count_after", {29'd0, count_o}, 32'd2);
    tick();
    push_ent(3'd7, 17'h18000, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    push_ent(3'd5, 17'h10000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    ready_i = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    chk("drain3_count", {29'd0, count_o}, 32'd0);
    tick();

`ifdef ALU_RESP_STATS_EN
    stat_clr_i = 1'b1;
    tick();
    stat_clr_i = 1'b0;
    push_ent(3'd0, 17'h10001, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    push_ent(3'd1, 17'h1FFFF, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    push_ent(3'd2, 17'h00000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("stat_push", {16'd0, stat_push_cnt_o}, 32'd3);
    chk("stat_carry", {16'd0, stat_carry_cnt_o}, 32'd2);
    chk("stat_zero", {16'd0, stat_zero_cnt_o}, 32'd1);
    tick();
    stat_clr_i = 1'b1;
    push_ent(3'd0, 17'h10000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    stat_clr_i = 1'b0;
    @(negedge clk);
    chk("stat_clr_push", {16'd0, stat_push_cnt_o}, 32'd0);
    chk("stat_clr_carry", {16'd0, stat_carry_cnt_o}, 32'd0);
    chk("stat_clr_zero", {16'd0, stat_zero_cnt_o}, 32'd0);
    tick();
    repeat (4) tick();
`endif

    @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    chk("final_count", {29'd0, count_o}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
